rr_burst_arbiter: RTL and testbench
===================================

// Module: rr_burst_arbiter
//
// PURPOSE
//   Round-robin arbiter that shares one streaming output bus between N_REQ
//   channel sources (e.g. per-channel event FIFOs feeding a readout path).
//   Grants the bus to one requester for a whole burst of req_len beats and
//   counts the beats as they transfer. At the end of the burst it passes
//   priority to the next requester. Sits between channel buffers and the
//   shared readout/packer stage.
//
// PARAMETERS
//   N_REQ   4   number of requesters (2..16)
//   LEN_W   8   width of per-requester burst length field
//   DATA_W  16  data beat width
//
// PORTS
//   clk        in   1             system clock, all logic on rising edge
//   rst_n      in   1             asynchronous active-low reset
//   req        in   N_REQ         per-requester burst request, level
//   req_len    in   N_REQ*LEN_W   burst length in beats, slice i = requester i
//   in_valid   in   N_REQ         per-requester data valid
//   in_data    in   N_REQ*DATA_W  per-requester data, slice i = requester i
//   in_ready   out  N_REQ         per-requester ready (only granted one may be 1)
//   out_valid  out  1             shared bus valid
//   out_data   out  DATA_W        shared bus data
//   out_last   out  1             marks final beat of burst (qualified by out_valid)
//   out_ready  in   1             downstream ready
//   grant      out  N_REQ         one-hot current owner, 0 when idle
//   busy       out  1             1 while a burst is in progress
//
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE, grant=0, busy=0, rr_ptr=0,
//     beat_cnt=0; therefore in_ready=0, out_valid=0, out_last=0, out_data=0.
//   - FSM states: IDLE, XFER.
//   - IDLE: if any req bit is set, select the first set bit searching from
//     rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., N_REQ-1, 0, ...).
//     Register the selection into grant and latch its req_len into len_q.
//     Then go to XFER. Grant appears 1 cycle after req is sampled high.
//     If no req bit is set, stay in IDLE.
//   - req_len==0 is treated as 1 beat.
//   - XFER (owner g): out_valid = in_valid[g], out_data = in_data[g],
//     in_ready[g] = out_ready. This mux is combinational, so the path adds no
//     extra latency. All other in_ready bits are 0.
//   - A beat transfers when out_valid && out_ready; only then beat_cnt increments.
//     out_last = (beat_cnt == len_q-1).
//   - On the handshake of the last beat: beat_cnt=0, grant=0, busy=0,
//     rr_ptr = (g+1) mod N_REQ, return to IDLE. There is exactly 1 idle cycle
//     between consecutive bursts.
//   - Changes to req or req_len during XFER are ignored. A burst always runs to
//     len_q beats, even if req[g] drops.
//   - Gaps in in_valid[g] or stalls on out_ready hold state. out_data is not
//     required to be stable while out_valid=0.
//   - When out_valid=0, out_data is 0 (not a don't-care), for waveform clarity.
//   - Reset asserted mid-burst aborts immediately. All outputs go to reset
//     values and the partial burst is lost. After reset, arbitration restarts
//     at rr_ptr=0.
//   - busy = (state==XFER). grant is never more than one-hot.
//   - Widths: beat_cnt and len_q are LEN_W bits. The maximum burst is
//     2^LEN_W-1 beats, and no counter wraps inside a legal burst.
//
// TESTING
//   1. req=0001, req_len[0]=3, in_valid=1, out_ready=1 -> grant=0001 one cycle
//      later; 3 beats; out_last on beat 3; IDLE next cycle; busy=0.
//   2. req=1111, all len=1, held high -> grant sequence 0001,0010,0100,1000,0001
//      with one idle cycle between bursts.
//   3. Owner 2 with len=4 and out_ready pattern 1,0,0,1,1,0,1 -> exactly 4
//      handshakes; out_data/out_last stable while stalled; beat_cnt ends at 0.
//   4. req_len[1]=0 with req=0010 -> single beat with out_last=1 on it.
//   5. rst_n low for 1 cycle on beat 2 of a 5-beat burst by requester 3 ->
//      outputs 0 immediately; with req=1000 after release, grant returns to
//      1000, searching from rr_ptr=0.
//   6. req[0] drops on beat 1 of a len=3 burst, and req=0100 arrives meanwhile
//      -> burst 0 completes all 3 beats, then grant=0100.

Source files
------------

// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: one requester owns the shared stream bus for a
// whole burst of req_len beats, then priority rotates to the next index.
module rr_burst_arbiter #(
    parameter int N_REQ  = 4,
    parameter int LEN_W  = 8,
    parameter int DATA_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ*LEN_W-1:0]    i_req_len,
    input  logic [N_REQ-1:0]          i_in_valid,
    input  logic [N_REQ*DATA_W-1:0]   i_in_data,
    output logic [N_REQ-1:0]          o_in_ready,
    output logic                      o_out_valid,
    output logic [DATA_W-1:0]         o_out_data,
    output logic                      o_out_last,
    input  logic                      i_out_ready,
    output logic [N_REQ-1:0]          o_grant,
    output logic                      o_busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {IDLE, XFER} state_t;

    state_t              r_state;
    logic [N_REQ-1:0]    r_grant;
    logic [IDX_W-1:0]    r_owner;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [LEN_W-1:0]    r_beat_cnt;
    logic [LEN_W-1:0]    r_len_q;

    logic [LEN_W-1:0]    w_len  [N_REQ];
    logic [DATA_W-1:0]   w_data [N_REQ];
    logic                w_xfer;
    logic                w_sel_found;
    logic [IDX_W-1:0]    w_sel_idx;
    logic [IDX_W:0]      w_cand;
    logic                w_last;
    logic                w_hs;

    assign w_xfer = (r_state == XFER);

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign w_len[gi]      = i_req_len[gi*LEN_W +: LEN_W];
            assign w_data[gi]     = i_in_data[gi*DATA_W +: DATA_W];
            assign o_in_ready[gi] = w_xfer && (r_owner == IDX_W'(gi)) && i_out_ready;
        end
    endgenerate

    // First set request at or above rr_ptr, wrapping around to index 0.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = r_rr_ptr;
        w_cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (w_cand >= (IDX_W+1)'(N_REQ))
                w_cand = w_cand - (IDX_W+1)'(N_REQ);
            if (!w_sel_found && i_req[w_cand[IDX_W-1:0]]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_cand[IDX_W-1:0];
            end
        end
    end

    assign w_last      = (r_beat_cnt == r_len_q - LEN_W'(1));
    assign o_out_valid = w_xfer && i_in_valid[r_owner];
    assign o_out_data  = o_out_valid ? w_data[r_owner] : '0;
    assign o_out_last  = w_xfer && w_last;
    assign w_hs        = o_out_valid && i_out_ready;
    assign o_grant     = r_grant;
    assign o_busy      = w_xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
            r_len_q    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_sel_found) begin
                        r_state    <= XFER;
                        r_owner    <= w_sel_idx;
                        r_grant    <= N_REQ'(1) << w_sel_idx;
                        r_beat_cnt <= '0;
                        // A zero length still moves one beat.
                        r_len_q    <= (w_len[w_sel_idx] == '0) ? LEN_W'(1) : w_len[w_sel_idx];
                    end
                end
                XFER: begin
                    if (w_hs) begin
                        if (w_last) begin
                            r_state    <= IDLE;
                            r_grant    <= '0;
                            r_beat_cnt <= '0;
                            r_rr_ptr   <= (r_owner == IDX_W'(N_REQ-1)) ? '0 : r_owner + IDX_W'(1);
                        end else begin
                            r_beat_cnt <= r_beat_cnt + LEN_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed bench for rr_burst_arbiter: arbitration order, burst length,
// stalls, zero length, mid-burst reset and ignored request changes.
module tb_rr_burst_arbiter;

    localparam int N  = 4;
    localparam int LW = 8;
    localparam int DW = 16;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [LW-1:0]   len [N];
    logic [N*LW-1:0] req_len;
    logic [N-1:0]    in_valid;
    logic [DW-1:0]   dat [N];
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic            out_ready;
    logic [N-1:0]    grant;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;

    assign req_len = {len[3], len[2], len[1], len[0]};
    assign in_data = {dat[3], dat[2], dat[1], dat[0]};

    rr_burst_arbiter #(.N_REQ(N), .LEN_W(LW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (req),
        .i_req_len   (req_len),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .o_in_ready  (in_ready),
        .o_out_valid (out_valid),
        .o_out_data  (out_data),
        .o_out_last  (out_last),
        .i_out_ready (out_ready),
        .o_grant     (grant),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".grant"},    32'(grant),     32'h0);
        chk({tag, ".busy"},     32'(busy),      32'h0);
        chk({tag, ".in_ready"}, 32'(in_ready),  32'h0);
        chk({tag, ".valid"},    32'(out_valid), 32'h0);
        chk({tag, ".last"},     32'(out_last),  32'h0);
        chk({tag, ".data"},     32'(out_data),  32'h0);
    endtask

    logic [6:0] pat;
    int hs;

    initial begin
        rst_n = 1'b0; req = '0; in_valid = '0; out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            len[i] = '0;
            dat[i] = 16'(16'h1111 * (i + 1));
        end

        // Reset state
        step(); step();
        chk_idle("reset");
        rst_n = 1'b1;
        step();

        // Single 3-beat burst from requester 0
        req = 4'b0001; len[0] = 8'd3; in_valid = 4'hF; out_ready = 1'b1;
        step();
        req = 4'b0000;
        chk("t1.grant", 32'(grant), 32'h1);
        chk("t1.busy", 32'(busy), 32'h1);
        chk("t1.in_ready", 32'(in_ready), 32'h1);
        chk("t1.data", 32'(out_data), 32'h1111);
        chk("t1.last0", 32'(out_last), 32'h0);
        step();
        chk("t1.last1", 32'(out_last), 32'h0);
        step();
        chk("t1.last2", 32'(out_last), 32'h1);
        step();
        chk_idle("t1.end");

        // Restart from rr_ptr 0, all four requesting 1-beat bursts
        rst_n = 1'b0; step(); rst_n = 1'b1;
        for (int i = 0; i < N; i++) len[i] = 8'd1;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("t2.grant%0d", i), 32'(grant), 32'(1 << (i % 4)));
            chk($sformatf("t2.data%0d", i), 32'(out_data), 32'(16'h1111 * ((i % 4) + 1)));
            chk($sformatf("t2.last%0d", i), 32'(out_last), 32'h1);
            step();
            chk($sformatf("t2.gap%0d", i), 32'(grant), 32'h0);
        end
        req = 4'b0000;

        // Owner 2, len 4, stalls on out_ready (rr_ptr is now 1)
        req = 4'b0100; len[2] = 8'd4; dat[2] = 16'hC000;
        step();
        req = 4'b0000;
        chk("t3.grant", 32'(grant), 32'h4);
        pat = 7'b1011001;   // bit j = out_ready in cycle j: 1,0,0,1,1,0,1
        hs = 0;
        for (int j = 0; j < 7; j++) begin
            out_ready = pat[j];
            #1;
            chk($sformatf("t3.valid%0d", j), 32'(out_valid), 32'h1);
            chk($sformatf("t3.data%0d", j), 32'(out_data), 32'(16'hC000 + hs));
            chk($sformatf("t3.last%0d", j), 32'(out_last), 32'(hs == 3));
            chk($sformatf("t3.rdy%0d", j), 32'(in_ready), pat[j] ? 32'h4 : 32'h0);
            step();
            if (pat[j]) begin
                hs++;
                dat[2] = 16'(16'hC000 + hs);
            end
        end
        out_ready = 1'b1;
        chk_idle("t3.end");

        // Zero length from requester 1 is one beat (rr_ptr 3 wraps to 1)
        req = 4'b0010; len[1] = 8'd0;
        step();
        req = 4'b0000;
        chk("t4.grant", 32'(grant), 32'h2);
        chk("t4.last", 32'(out_last), 32'h1);
        chk("t4.data", 32'(out_data), 32'h2222);
        step();
        chk_idle("t4.end");

        // Reset during beat 2 of a 5-beat burst from requester 3
        req = 4'b1000; len[3] = 8'd5;
        step();
        chk("t5.grant", 32'(grant), 32'h8);
        step();
        chk("t5.last", 32'(out_last), 32'h0);
        rst_n = 1'b0;
        #1;
        chk_idle("t5.rst");
        step();
        rst_n = 1'b1;
        // Requesters 0 and 3 both ask: rr_ptr back at 0 picks requester 0
        req = 4'b1001; len[0] = 8'd1;
        step();
        req = 4'b0000;
        chk("t5.regrant", 32'(grant), 32'h1);
        step();
        chk("t5.idle", 32'(busy), 32'h0);

        // req[0] drops during burst while req[2] arrives
        req = 4'b0001; len[0] = 8'd3;
        step();
        chk("t6.grant0", 32'(grant), 32'h1);
        req = 4'b0100;
        step();
        chk("t6.hold1", 32'(grant), 32'h1);
        chk("t6.last1", 32'(out_last), 32'h0);
        step();
        chk("t6.hold2", 32'(grant), 32'h1);
        chk("t6.last2", 32'(out_last), 32'h1);
        step();
        chk("t6.gap", 32'(grant), 32'h0);
        step();
        req = 4'b0000;
        chk("t6.grant2", 32'(grant), 32'h4);
        step(); step(); step(); step();
        chk("t6.end", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
